vote_button_arbiter: RTL and testbench
======================================

VOTE_BUTTON_ARBITER -- requirements
Module: vote_button_arbiter

Interface
REQ-001 Parameter N_CH, default 4: number of candidate buttons; legal range 2..16.
REQ-002 Parameter HOLD_CYCLES, default 5: consecutive sampled-high cycles required to accept a vote; legal minimum 1.
REQ-003 Parameter LOCKOUT_CYCLES, default 2: dead cycles after release before re-arm; 0 is legal.
REQ-004 Derived widths SHALL be CH_W = max(1, clog2(N_CH)) and CNT_W = clog2(max(HOLD_CYCLES, LOCKOUT_CYCLES) + 1).
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 button  input  N_CH  raw candidate buttons, 1 = pressed.
REQ-008 valid_vote  output  1  one-cycle pulse, a vote is accepted.
REQ-009 vote_ch  output  CH_W  binary index of the accepted channel; 0 when valid_vote is low.
REQ-010 vote_onehot  output  N_CH  one-hot of the accepted channel; 0 when valid_vote is low.
REQ-011 conflict  output  1  one-cycle pulse, a multi-button press is rejected.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, COUNT, WAIT_REL and LOCK; all outputs SHALL be registered.
REQ-014 Sampled vector s SHALL be button (or the synchronised button per REQ-028); "single" means s is one-hot and "multi" means popcount(s) >= 2.
REQ-015 IDLE with single: latch the channel, set cnt = 1, go to COUNT; if HOLD_CYCLES = 1, instead pulse valid_vote and go directly to WAIT_REL.
REQ-016 IDLE with multi: pulse conflict the next cycle, go to WAIT_REL, latch nothing.
REQ-017 IDLE with s = 0: remain in IDLE.
REQ-018 COUNT with s equal to the latched one-hot: if cnt + 1 == HOLD_CYCLES, pulse valid_vote with vote_ch/vote_onehot and go to WAIT_REL; otherwise increment cnt.
REQ-019 COUNT with s = 0 (early release): return to IDLE, clear cnt, emit no pulse.
REQ-020 COUNT with any other non-zero s (second button added or channel swapped): pulse conflict, go to WAIT_REL, emit no vote.
REQ-021 Latency SHALL be as follows: a button high at HOLD_CYCLES consecutive sampling edges gives valid_vote high for exactly the one cycle after the last of those edges.
REQ-022 Exactly one vote SHALL be produced per press regardless of hold duration; re-voting requires a full release.
REQ-023 WAIT_REL: remain there until s = 0, then go to LOCK with cnt = 0 if LOCKOUT_CYCLES > 0, else to IDLE.
REQ-024 LOCK: ignore button, count LOCKOUT_CYCLES cycles, then go to IDLE; a button held at the exit SHALL be treated as a fresh press in IDLE.
REQ-025 valid_vote and conflict SHALL never be high in the same cycle.

Reset
REQ-026 When rst is high at a clock edge: state = IDLE, cnt = 0, latched channel = 0, valid_vote = 0, vote_ch = 0, vote_onehot = 0, conflict = 0, busy = 0.
REQ-027 rst mid-COUNT SHALL discard the partial count with no pulse; a button still held after reset release SHALL be counted from 1.

Configuration
REQ-028 Macro VOTE_BUTTON_SYNC_EN defined: button SHALL pass through a 2-flop synchroniser per bit, reset to 0, adding 2 cycles to all input-to-output latencies.
REQ-029 Macro VOTE_BUTTON_SYNC_EN undefined: button SHALL be sampled directly, with latency per REQ-021.

Verification (defaults, macro undefined)
REQ-030 Hold button = 4'b0100 for 10 cycles -> valid_vote high exactly once, 1 cycle after the 5th sampling edge, vote_ch = 2, vote_onehot = 4'b0100; no further pulses.
REQ-031 Hold button = 4'b0001 for 4 cycles then release -> no valid_vote, FSM back in IDLE, busy low.
REQ-032 button = 4'b0011 at once; separately, 4'b0001 for 2 cycles then 4'b0011 -> one conflict pulse each, no vote, busy until release + 2 cycles.
REQ-033 Vote on ch1, release, press ch3 during LOCK, hold 8 cycles -> second vote_ch = 3 with the count starting at LOCK exit.
REQ-034 Assert rst at cnt = 3 with the button still held -> all outputs 0; after rst deasserts, the vote arrives 5 sampling edges later.
REQ-035 With VOTE_BUTTON_SYNC_EN defined, repeat REQ-030 -> pulse 2 cycles later than without the macro.

Source files
------------

// File: rtl/vote_button_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vote_button_arbiter
// Description : Debounced single-vote button arbiter with multi-press
//               conflict rejection and post-release lockout.
//               Optional input synchroniser: define VOTE_BUTTON_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vote_button_arbiter #(
    parameter int N_CH           = 4,
    parameter int HOLD_CYCLES    = 5,
    parameter int LOCKOUT_CYCLES = 2,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int CNT_W = $clog2(((HOLD_CYCLES > LOCKOUT_CYCLES) ?
                                   HOLD_CYCLES : LOCKOUT_CYCLES) + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] button,
    output logic            valid_vote,
    output logic [CH_W-1:0] vote_ch,
    output logic [N_CH-1:0] vote_onehot,
    output logic            conflict,
    output logic            busy
);

    localparam logic [1:0]      c_idle     = 2'd0;
    localparam logic [1:0]      c_count    = 2'd1;
    localparam logic [1:0]      c_wait_rel = 2'd2;
    localparam logic [1:0]      c_lock     = 2'd3;
    localparam logic [N_CH-1:0] c_one      = N_CH'(1);
    localparam logic [CNT_W:0]  c_hold     = (CNT_W+1)'(HOLD_CYCLES);
    localparam logic [CNT_W:0]  c_lockout  = (CNT_W+1)'(LOCKOUT_CYCLES);

    logic [N_CH-1:0] w_s;

`ifdef VOTE_BUTTON_SYNC_EN
    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= button;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = button;
`endif

    logic [1:0]      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CH_W-1:0] r_ch;
    logic            r_valid;
    logic [CH_W-1:0] r_vote_ch;
    logic [N_CH-1:0] r_onehot;
    logic            r_conflict;
    logic            r_busy;

    logic            w_any;
    logic            w_single;
    logic [CH_W-1:0] w_idx;
    logic [N_CH-1:0] w_latched;
    logic [CNT_W:0]  w_cnt_inc;

    // Index encoder is only meaningful when w_s is one-hot.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_s[i]) w_idx = CH_W'(i);
        end
    end

    assign w_any     = |w_s;
    assign w_single  = w_any && ((w_s & (w_s - c_one)) == '0);
    assign w_latched = c_one << r_ch;
    assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_idle;
            r_cnt      <= '0;
            r_ch       <= '0;
            r_valid    <= 1'b0;
            r_vote_ch  <= '0;
            r_onehot   <= '0;
            r_conflict <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_valid    <= 1'b0;
            r_vote_ch  <= '0;
            r_onehot   <= '0;
            r_conflict <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (w_single) begin
                        r_ch   <= w_idx;
                        r_busy <= 1'b1;
                        if (HOLD_CYCLES == 1) begin
                            r_valid   <= 1'b1;
                            r_vote_ch <= w_idx;
                            r_onehot  <= w_s;
                            r_cnt     <= '0;
                            r_state   <= c_wait_rel;
                        end else begin
                            r_cnt   <= CNT_W'(1);
                            r_state <= c_count;
                        end
                    end else if (w_any) begin
                        r_conflict <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= c_wait_rel;
                    end
                end
                c_count: begin
                    if (w_s == w_latched) begin
                        if (w_cnt_inc == c_hold) begin
                            r_valid   <= 1'b1;
                            r_vote_ch <= r_ch;
                            r_onehot  <= w_latched;
                            r_cnt     <= '0;
                            r_state   <= c_wait_rel;
                        end else begin
                            r_cnt <= w_cnt_inc[CNT_W-1:0];
                        end
                    end else if (!w_any) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= c_idle;
                    end else begin
                        r_conflict <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= c_wait_rel;
                    end
                end
                c_wait_rel: begin
                    if (!w_any) begin
                        r_cnt <= '0;
                        if (LOCKOUT_CYCLES > 0) begin
                            r_state <= c_lock;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= c_idle;
                        end
                    end
                end
                c_lock: begin
                    // Buttons are ignored here; a press still held at exit is seen fresh in idle.
                    if (w_cnt_inc == c_lockout) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= c_idle;
                    end else begin
                        r_cnt <= w_cnt_inc[CNT_W-1:0];
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign valid_vote  = r_valid;
    assign vote_ch     = r_vote_ch;
    assign vote_onehot = r_onehot;
    assign conflict    = r_conflict;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vote_button_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vote_button_arbiter
// Description : Directed plus randomized bench for vote_button_arbiter with a
//               press/release level reference model (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vote_button_arbiter;

    localparam int N_CH           = 4;
    localparam int HOLD_CYCLES    = 5;
    localparam int LOCKOUT_CYCLES = 2;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [3:0] button = 4'b0000;
    logic       valid_vote;
    logic [1:0] vote_ch;
    logic [3:0] vote_onehot;
    logic       conflict;
    logic       busy;

    always #5 clk = ~clk;

    vote_button_arbiter #(
        .N_CH           (N_CH),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .button      (button),
        .valid_vote  (valid_vote),
        .vote_ch     (vote_ch),
        .vote_onehot (vote_onehot),
        .conflict    (conflict),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a press is a run of identical one-hot samples while armed.
    bit         m_need_release;
    int         m_lock_left;
    logic [3:0] m_run_val;
    int         m_run_len;
    logic       m_valid;
    logic       m_conf;
    logic [3:0] m_vote_val;

    int         vote_seen;
    int         conf_seen;
    int         last_vote_ch;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_need_release = 1'b0;
        m_lock_left    = 0;
        m_run_val      = '0;
        m_run_len      = 0;
        m_valid        = 1'b0;
        m_conf         = 1'b0;
        m_vote_val     = '0;
    endtask

    task automatic model_step(input logic [3:0] s);
        m_valid = 1'b0;
        m_conf  = 1'b0;
        if (m_need_release) begin
            if (s == 4'b0000) begin
                m_need_release = 1'b0;
                m_lock_left    = LOCKOUT_CYCLES;
            end
        end else if (m_lock_left > 0) begin
            m_lock_left--;
        end else if (s == 4'b0000) begin
            m_run_len = 0;
        end else if ($countones(s) > 1 || (m_run_len > 0 && s != m_run_val)) begin
            m_conf         = 1'b1;
            m_need_release = 1'b1;
            m_run_len      = 0;
        end else begin
            m_run_val = s;
            m_run_len++;
            if (m_run_len == HOLD_CYCLES) begin
                m_valid        = 1'b1;
                m_vote_val     = s;
                m_need_release = 1'b1;
                m_run_len      = 0;
            end
        end
    endtask

    function automatic int onehot_index(input logic [3:0] v);
        int idx = 0;
        for (int i = 0; i < 4; i++) if (v[i]) idx = i;
        return idx;
    endfunction

    task automatic check_outputs();
        logic exp_busy;
        exp_busy = m_need_release || (m_lock_left > 0) || (m_run_len > 0);
        chk("valid_vote",  valid_vote,  m_valid);
        chk("vote_ch",     vote_ch,     m_valid ? onehot_index(m_vote_val) : 0);
        chk("vote_onehot", vote_onehot, m_valid ? m_vote_val : 4'b0000);
        chk("conflict",    conflict,    m_conf);
        chk("busy",        busy,        exp_busy);
        chk("exclusive",   valid_vote & conflict, 1'b0);
        if (valid_vote === 1'b1) begin
            vote_seen++;
            last_vote_ch = int'(vote_ch);
        end
        if (conflict === 1'b1) conf_seen++;
    endtask

    task automatic tick(input logic [3:0] s, input bit r = 1'b0);
        @(negedge clk);
        button = s;
        rst    = r;
        @(posedge clk);
        if (r) model_reset();
        else   model_step(s);
        #1;
        check_outputs();
    endtask

    task automatic hold(input logic [3:0] s, input int n);
        for (int i = 0; i < n; i++) tick(s);
    endtask

    initial begin
        model_reset();
        vote_seen    = 0;
        conf_seen    = 0;
        last_vote_ch = -1;

        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b1);
        chk("reset_busy",  busy,       1'b0);
        chk("reset_valid", valid_vote, 1'b0);

        // Long hold of channel 2: exactly one vote.
        vote_seen = 0;
        hold(4'b0100, 4);
        chk("hold4_no_vote", vote_seen, 0);
        tick(4'b0100);
        chk("fifth_edge_vote", valid_vote, 1'b1);
        chk("fifth_edge_ch",   vote_ch,    2);
        hold(4'b0100, 5);
        chk("long_hold_votes", vote_seen, 1);
        hold(4'b0000, 3);

        // Early release.
        vote_seen = 0;
        hold(4'b0001, 4);
        tick(4'b0000);
        chk("early_rel_votes", vote_seen, 0);
        chk("early_rel_busy",  busy,      1'b0);

        // Immediate double press.
        conf_seen = 0;
        vote_seen = 0;
        hold(4'b0011, 2);
        tick(4'b0000);
        chk("dbl_busy_lock", busy, 1'b1);
        hold(4'b0000, 2);
        chk("dbl_conf",      conf_seen, 1);
        chk("dbl_busy_done", busy,      1'b0);

        // Second button added mid-count.
        conf_seen = 0;
        hold(4'b0001, 2);
        hold(4'b0011, 2);
        hold(4'b0000, 3);
        chk("add_conf",  conf_seen, 1);
        chk("add_votes", vote_seen, 0);

        // Vote ch1, release, press ch3 during lockout.
        vote_seen = 0;
        hold(4'b0010, 5);
        tick(4'b0000);
        hold(4'b1000, 6);
        chk("lock_no_early_vote", vote_seen, 1);
        tick(4'b1000);
        chk("lock_second_vote", vote_seen,    2);
        chk("lock_second_ch",   last_vote_ch, 3);
        hold(4'b1000, 1);
        hold(4'b0000, 3);

        // Reset mid-count with the button still held.
        vote_seen = 0;
        hold(4'b0001, 3);
        tick(4'b0001, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        hold(4'b0001, 4);
        chk("rst_mid_no_vote", vote_seen, 0);
        tick(4'b0001);
        chk("rst_mid_vote", vote_seen, 1);
        hold(4'b0000, 3);

        // Randomized bursts.
        for (int b = 0; b < 120; b++) begin
            logic [3:0] pat;
            int         sel;
            int         len;
            sel = int'($urandom_range(0, 9));
            len = int'($urandom_range(1, 8));
            if (sel <= 5)      pat = 4'b0001 << $urandom_range(0, 3);
            else if (sel <= 7) pat = 4'b0000;
            else               pat = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) tick(pat, 1'b1);
            hold(pat, len);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
